pacman_motion_ctrl: RTL and testbench

PACMAN_MOTION_CTRL -- requirements
Module: pacman_motion_ctrl

---
 rtl/pacman_motion_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pacman_motion_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pacman_motion_ctrl.sv
// pacman_motion_ctrl
// Moves the Pac-Man sprite one STEP per video frame in the direction chosen by
// the buttons. The sprite stops at the playfield edges. Its animation frame
// advances every ANIM_DIV frames in which the sprite actually moves.
//
// Ports
//   clk           system clock (the only clock)
//   rst_n         asynchronous active-low reset
//   frame_start   one-cycle pulse when the raster wraps to line 0
//   btn[3:0]      raw asynchronous buttons: [3] up, [2] down, [1] left, [0] right
//   pac_x/pac_y   sprite top-left position (registered)
//   dir           current direction: 0 up, 1 down, 2 left, 3 right (registered)
//   frame_select  animation frame index to the sprite ROM (registered)
//   moving        high while the FSM is in MOVING (registered)
//
// Build option
//   PACMAN_WRAP_EN  when defined, horizontal motion wraps around the screen
//                   instead of stopping at the edges.
module pacman_motion_ctrl #(
    parameter int STEP     = 2,
    parameter int ANIM_DIV = 20,
    parameter int X_MAX    = 576,
    parameter int Y_MAX    = 416,
    parameter int X_START  = 288,
    parameter int Y_START  = 208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic [3:0] btn,
    output logic [9:0] pac_x,
    output logic [9:0] pac_y,
    output logic [1:0] dir,
    output logic [1:0] frame_select,
    output logic       moving
);

    typedef enum logic [1:0] {S_IDLE, S_MOVING, S_BLOCKED} state_t;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [9:0]        X_MAX_C   = 10'(X_MAX);
    localparam logic [9:0]        Y_MAX_C   = 10'(Y_MAX);
    localparam logic [9:0]        X_START_C = 10'(X_START);
    localparam logic [9:0]        Y_START_C = 10'(Y_START);
    localparam logic signed [10:0] STEP_S   = 11'(STEP);
    localparam logic [4:0]        ANIM_LAST = 5'(ANIM_DIV - 1);

`ifdef PACMAN_WRAP_EN
    localparam logic WRAP_H = 1'b1;
`else
    localparam logic WRAP_H = 1'b0;
`endif

    // One step along an axis. The sum is formed at 11 bits, signed, so that an
    // underflow below 0 is visible before clamping or wrapping.
    function automatic logic [9:0] step_coord(input logic [9:0] pos,
                                              input logic       dec,
                                              input logic       wrap,
                                              input logic [9:0] lim);
        logic signed [10:0] sum;
        logic signed [10:0] lim_s;
        lim_s = $signed({1'b0, lim});
        if (dec) sum = $signed({1'b0, pos}) - STEP_S;
        else     sum = $signed({1'b0, pos}) + STEP_S;
        if (sum < 11'sd0)      step_coord = wrap ? lim : 10'd0;
        else if (sum > lim_s)  step_coord = wrap ? 10'd0 : lim;
        else                   step_coord = sum[9:0];
    endfunction

    // True when the sprite sits on the edge that direction d points into.
    // A wrapping horizontal axis has no edge.
    function automatic logic at_limit(input logic [1:0] d,
                                      input logic [9:0] x,
                                      input logic [9:0] y);
        case (d)
            DIR_UP:   at_limit = (y == 10'd0);
            DIR_DOWN: at_limit = (y == Y_MAX_C);
            DIR_LEFT: at_limit = !WRAP_H && (x == 10'd0);
            default:  at_limit = !WRAP_H && (x == X_MAX_C);
        endcase
    endfunction

    logic [3:0] btn_s1_q, btn_s2_q;
    logic [1:0] pend_dir_q;
    logic       pend_valid_q;
    state_t     state_q, state_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic [1:0] dir_q, dir_d;
    logic [1:0] fsel_q, fsel_d;
    logic [4:0] anim_q, anim_d;
    logic       moving_q, moving_d;
    logic       do_step;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        fsel_d  = fsel_q;
        anim_d  = anim_q;
        do_step = 1'b0;

        if (frame_start) begin
            case (state_q)
                S_IDLE:    do_step = pend_valid_q;
                S_MOVING:  do_step = 1'b1;
                default:   do_step = (pend_dir_q != dir_q) &&
                                     !at_limit(pend_dir_q, x_q, y_q);
            endcase
        end

        if (do_step) begin
            dir_d   = pend_dir_q;
            state_d = S_MOVING;
            case (pend_dir_q)
                DIR_UP:   y_d = step_coord(y_q, 1'b1, 1'b0, Y_MAX_C);
                DIR_DOWN: y_d = step_coord(y_q, 1'b0, 1'b0, Y_MAX_C);
                DIR_LEFT: x_d = step_coord(x_q, 1'b1, WRAP_H, X_MAX_C);
                default:  x_d = step_coord(x_q, 1'b0, WRAP_H, X_MAX_C);
            endcase
            // Only a step taken from MOVING can run into a wall; leaving IDLE
            // or BLOCKED always lands in MOVING first.
            if (state_q == S_MOVING && at_limit(pend_dir_q, x_d, y_d))
                state_d = S_BLOCKED;
            // The animation advances on every frame that moves the sprite.
            if (anim_q == ANIM_LAST) begin
                anim_d = 5'd0;
                fsel_d = fsel_q + 2'd1;
            end else begin
                anim_d = anim_q + 5'd1;
            end
        end

        moving_d = (state_d == S_MOVING);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q     <= '0;
            btn_s2_q     <= '0;
            pend_dir_q   <= DIR_RIGHT;
            pend_valid_q <= 1'b0;
            state_q      <= S_IDLE;
            x_q          <= X_START_C;
            y_q          <= Y_START_C;
            dir_q        <= DIR_RIGHT;
            fsel_q       <= 2'd0;
            anim_q       <= 5'd0;
            moving_q     <= 1'b0;
        end else begin
            btn_s1_q <= btn;
            btn_s2_q <= btn_s1_q;
            // Latch the highest-priority pressed button; releasing all keeps it.
            if (|btn_s2_q) begin
                pend_valid_q <= 1'b1;
                if (btn_s2_q[3])      pend_dir_q <= DIR_UP;
                else if (btn_s2_q[2]) pend_dir_q <= DIR_DOWN;
                else if (btn_s2_q[1]) pend_dir_q <= DIR_LEFT;
                else                  pend_dir_q <= DIR_RIGHT;
            end
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dir_q    <= dir_d;
            fsel_q   <= fsel_d;
            anim_q   <= anim_d;
            moving_q <= moving_d;
        end
    end

    assign pac_x        = x_q;
    assign pac_y        = y_q;
    assign dir          = dir_q;
    assign frame_select = fsel_q;
    assign moving       = moving_q;

endmodule

// File: tb/tb_pacman_motion_ctrl.sv
// Testbench for pacman_motion_ctrl: directed scenarios plus randomized button
// and frame sequences, each checked against a behavioural position model.
module tb_pacman_motion_ctrl;

    localparam int STEP     = 2;
    localparam int ANIM_DIV = 20;
    localparam int X_MAX    = 576;
    localparam int Y_MAX    = 416;
    localparam int X_START  = 288;
    localparam int Y_START  = 208;
`ifdef PACMAN_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       frame_start = 1'b0;
    logic [3:0] btn = 4'd0;
    logic [9:0] pac_x, pac_y;
    logic [1:0] dir, frame_select;
    logic       moving;

    int n_checks = 0;
    int n_pass   = 0;

    pacman_motion_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .btn          (btn),
        .pac_x        (pac_x),
        .pac_y        (pac_y),
        .dir          (dir),
        .frame_select (frame_select),
        .moving       (moving)
    );

    always #5 clk = ~clk;

    wire [24:0] dut_vec = {pac_x, pac_y, dir, frame_select, moving};
    localparam logic [24:0] RESET_VEC = {10'd288, 10'd208, 2'd3, 2'd0, 1'b0};

    // Behavioural model: position as integers, mode as 0 idle / 1 moving / 2 blocked.
    int m_x, m_y, m_dir, m_mode, m_pend, m_steps;
    bit m_pvalid;

    function automatic bit m_wall(input int d, input int x, input int y);
        case (d)
            0: return y == 0;
            1: return y == Y_MAX;
            2: return !WRAP && x == 0;
            default: return !WRAP && x == X_MAX;
        endcase
    endfunction

    function automatic logic [24:0] exp_vec();
        return {10'(m_x), 10'(m_y), 2'(m_dir), 2'((m_steps / ANIM_DIV) % 4), (m_mode == 1)};
    endfunction

    task automatic model_reset();
        m_x = X_START; m_y = Y_START; m_dir = 3; m_mode = 0;
        m_pend = 3; m_pvalid = 0; m_steps = 0;
    endtask

    task automatic model_frame();
        bit go;
        int was;
        go  = (m_mode == 0) ? m_pvalid :
              (m_mode == 1) ? 1'b1 :
              (m_pend != m_dir && !m_wall(m_pend, m_x, m_y));
        if (!go) return;
        was   = m_mode;
        m_dir = m_pend;
        case (m_dir)
            0: m_y = (m_y - STEP < 0) ? 0 : m_y - STEP;
            1: m_y = (m_y + STEP > Y_MAX) ? Y_MAX : m_y + STEP;
            2: m_x = (m_x - STEP < 0) ? (WRAP ? X_MAX : 0) : m_x - STEP;
            default: m_x = (m_x + STEP > X_MAX) ? (WRAP ? 0 : X_MAX) : m_x + STEP;
        endcase
        m_mode = (was == 1 && m_wall(m_dir, m_x, m_y)) ? 2 : 1;
        m_steps++;
    endtask

    // Drive buttons and wait for them to cross the synchronizer into pend_dir.
    task automatic set_btn(input logic [3:0] b);
        @(negedge clk);
        btn = b;
        repeat (4) @(negedge clk);
        if (b != 0) begin
            m_pvalid = 1;
            m_pend = b[3] ? 0 : b[2] ? 1 : b[1] ? 2 : 3;
        end
    endtask

    // One isolated frame_start pulse; returns at a negedge after the update edge.
    task automatic pulse();
        @(negedge clk);
        frame_start = 1'b1;
        model_frame();
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut_vec !== RESET_VEC) $display("FAIL reset_async: got %h want %h", dut_vec, RESET_VEC);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        n_checks++;
        if (dut_vec !== RESET_VEC) $display("FAIL reset_hold: got %h want %h", dut_vec, RESET_VEC);
        else n_pass++;
    endtask

    task automatic test_right10();
        do_reset();
        pulse();
        n_checks++;
        if (dut_vec !== RESET_VEC) $display("FAIL idle_no_button: got %h want %h", dut_vec, RESET_VEC);
        else n_pass++;
        set_btn(4'b0001);
        repeat (10) pulse();
        n_checks++;
        if (dut_vec !== {10'd308, 10'd208, 2'd3, 2'd0, 1'b1} || dut_vec !== exp_vec())
            $display("FAIL right10: got %h want %h", dut_vec, exp_vec());
        else n_pass++;
        set_btn(4'b0000);
        pulse();
        n_checks++;
        if (dut_vec !== exp_vec() || pac_x !== 10'd310)
            $display("FAIL release_keeps_dir: got %h want %h", dut_vec, exp_vec());
        else n_pass++;
    endtask

    task automatic test_wall_and_anim();
        do_reset();
        set_btn(4'b0001);
        for (int f = 1; f <= 145; f++) begin
            pulse();
            if (f == 20 || f == 80 || f == 144 || f == 145) begin
                n_checks++;
                if (dut_vec !== exp_vec())
                    $display("FAIL wall_frame%0d: got %h want %h", f, dut_vec, exp_vec());
                else n_pass++;
            end
            if (!WRAP && f == 20) begin
                n_checks++;
                if (frame_select !== 2'd1) $display("FAIL anim20: got %0d want 1", frame_select);
                else n_pass++;
            end
            if (!WRAP && f == 80) begin
                n_checks++;
                if (frame_select !== 2'd0) $display("FAIL anim80: got %0d want 0", frame_select);
                else n_pass++;
            end
            if (!WRAP && (f == 144 || f == 145)) begin
                n_checks++;
                if (pac_x !== 10'd576 || moving !== 1'b0 || frame_select !== 2'd3)
                    $display("FAIL blocked%0d: got x=%0d mv=%0d fs=%0d want x=576 mv=0 fs=3",
                             f, pac_x, moving, frame_select);
                else n_pass++;
            end
        end
        // Turn away from the wall (or keep wrapping) with up.
        set_btn(4'b1000);
        pulse();
        n_checks++;
        if (dut_vec !== exp_vec() || dir !== 2'd0 || moving !== 1'b1)
            $display("FAIL turn_off_wall: got %h want %h", dut_vec, exp_vec());
        else n_pass++;
    endtask

    task automatic test_priority();
        do_reset();
        set_btn(4'b1010);
        pulse();
        n_checks++;
        if (dut_vec !== {10'd288, 10'd206, 2'd0, 2'd0, 1'b1} || dut_vec !== exp_vec())
            $display("FAIL up_left_priority: got %h want %h", dut_vec, exp_vec());
        else n_pass++;
    endtask

    task automatic test_left_edge();
        do_reset();
        set_btn(4'b0010);
        repeat (144) pulse();
        n_checks++;
        if (pac_x !== 10'd0 || dut_vec !== exp_vec())
            $display("FAIL left_to_zero: got %h want %h", dut_vec, exp_vec());
        else n_pass++;
        pulse();
        n_checks++;
        if (dut_vec !== exp_vec() || pac_x !== (WRAP ? 10'd576 : 10'd0) || moving !== WRAP)
            $display("FAIL left_edge_next: got x=%0d mv=%0d want x=%0d mv=%0d",
                     pac_x, moving, WRAP ? 576 : 0, WRAP);
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        do_reset();
        set_btn(4'b0001);
        pulse();
        @(negedge clk);
        btn = 4'b1000;
        frame_start = 1'b1;
        model_frame();
        @(negedge clk);
        frame_start = 1'b0;
        n_checks++;
        if (dut_vec !== exp_vec() || pac_x !== 10'd292 || dir !== 2'd3)
            $display("FAIL same_cycle_old_dir: got %h want %h", dut_vec, exp_vec());
        else n_pass++;
        repeat (4) @(negedge clk);
        m_pend = 0;
        pulse();
        n_checks++;
        if (dut_vec !== exp_vec() || pac_y !== 10'd206)
            $display("FAIL same_cycle_then_up: got %h want %h", dut_vec, exp_vec());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_btn(4'b0100);
        @(negedge clk);
        frame_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            model_frame();
            @(negedge clk);
            if (i == 2) frame_start = 1'b0;
            n_checks++;
            if (dut_vec !== exp_vec())
                $display("FAIL back_to_back%0d: got %h want %h", i, dut_vec, exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        set_btn(4'b0001);
        repeat (5) pulse();
        @(negedge clk);
        frame_start = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut_vec !== RESET_VEC) $display("FAIL mid_reset_async: got %h want %h", dut_vec, RESET_VEC);
        else n_pass++;
        @(negedge clk);
        frame_start = 1'b0;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        n_checks++;
        if (dut_vec !== RESET_VEC) $display("FAIL mid_reset_discard: got %h want %h", dut_vec, RESET_VEC);
        else n_pass++;
        repeat (4) @(negedge clk);
        m_pvalid = 1;
        m_pend = 3;
        pulse();
        n_checks++;
        if (dut_vec !== exp_vec() || pac_x !== 10'd290)
            $display("FAIL after_reset_first: got %h want %h", dut_vec, exp_vec());
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int it = 0; it < 60; it++) begin
            set_btn(4'($urandom_range(0, 15)));
            repeat ($urandom_range(1, 40)) begin
                pulse();
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                n_checks++;
                if (dut_vec !== exp_vec())
                    $display("FAIL random_it%0d: got %h want %h", it, dut_vec, exp_vec());
                else n_pass++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_right10();
        test_wall_and_anim();
        test_priority();
        test_left_edge();
        test_same_cycle();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
